// File: rtl/fifo_frame_pkg.sv
// Shared definitions for the framed FIFO writer: state encoding, defaults, CRC-8 step.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package fifo_frame_pkg;

   // FSM state encoding, kept as plain vectors so older tools can consume it
   localparam logic [2:0] ST_COLLECT = 3'd0;
   localparam logic [2:0] ST_SOF     = 3'd1;
   localparam logic [2:0] ST_LEN     = 3'd2;
   localparam logic [2:0] ST_PAY     = 3'd3;
   localparam logic [2:0] ST_CHK     = 3'd4;

   localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;
   localparam logic [7:0] CRC8_POLY        = 8'h07;

   // One byte of CRC-8: MSB-first, no reflection, no final XOR
   function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
      end
      return c;
   endfunction

   // Address width for a buffer of the given depth (at least one bit)
   function automatic int buf_aw(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fifo_frame_buf.sv
// Payload staging RAM: DEPTH x 8, synchronous write, combinational read, no reset.
// Latency: write visible on read port the cycle after the write edge.
// Backpressure: none; the owner sequences reads and writes.
module fifo_frame_buf #(
   parameter int DEPTH = 255,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] mem [DEPTH];

   // Store accepted payload bytes
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_frame_writer.sv
// Collects a payload from a valid/ready source, then writes SOF, LEN, payload, check to a byte FIFO.
// Latency: SOF can be written the cycle after the last byte is accepted; a frame takes LEN+3 unstalled cycles.
// Backpressure: fifo_full stalls the write phase byte by byte; s_ready is low for the whole write phase.
// Build option: define FIFO_FRAME_WRITER_CRC8_EN for a CRC-8 check byte instead of XOR.
module fifo_frame_writer
   import fifo_frame_pkg::*;
#(
   parameter int         MAX_PAYLOAD = 255,
   parameter logic [7:0] SOF_BYTE    = SOF_BYTE_DEFAULT
) (
   input  logic        clk,
   input  logic        srst_n,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   input  logic        s_last,
   output logic        s_ready,
   output logic [7:0]  fifo_din,
   output logic        fifo_wr_en,
   input  logic        fifo_full,
   output logic [15:0] frames_sent,
   output logic        split_pulse
);

   localparam int         AW      = buf_aw(MAX_PAYLOAD);
   localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

   logic [2:0]  state_q,  state_d;
   logic [7:0]  cnt_q,    cnt_d;
   logic [7:0]  rd_idx_q, rd_idx_d;
   logic [7:0]  check_q,  check_d;
   logic [15:0] frames_q, frames_d;
   logic        split_q,  split_d;
   // Holds s_ready low until the first edge after reset release
   logic        run_q;

   logic        buf_wr_en;
   logic [7:0]  buf_rd_data;
   logic [7:0]  cnt_inc;
   logic        wr_ok;

   assign cnt_inc = cnt_q + 8'd1;
   assign wr_ok   = !fifo_full;

   fifo_frame_buf #(
      .DEPTH (MAX_PAYLOAD),
      .AW    (AW)
   ) u_buf (
      .clk     (clk),
      .wr_en   (buf_wr_en),
      .wr_addr (cnt_q[AW-1:0]),
      .wr_data (s_data),
      .rd_addr (rd_idx_q[AW-1:0]),
      .rd_data (buf_rd_data)
   );

   // Next-state, datapath and output decode for collect and write phases
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rd_idx_d   = rd_idx_q;
      check_d    = check_q;
      frames_d   = frames_q;
      split_d    = 1'b0;
      buf_wr_en  = 1'b0;
      s_ready    = 1'b0;
      fifo_wr_en = 1'b0;
      fifo_din   = 8'h00;

      case (state_q)
         ST_COLLECT: begin
            s_ready = run_q;
            if (s_valid && run_q) begin
               buf_wr_en = 1'b1;
               cnt_d     = cnt_inc;
`ifndef FIFO_FRAME_WRITER_CRC8_EN
               check_d   = check_q ^ s_data;
`endif
               if (s_last || (cnt_inc == MAX_LEN)) begin
                  state_d = ST_SOF;
                  // A close without s_last means the buffer filled up
                  split_d = !s_last;
`ifdef FIFO_FRAME_WRITER_CRC8_EN
                  // CRC starts with LEN; payload is folded in as it is written out
                  check_d = crc8_byte(8'h00, cnt_inc);
`else
                  check_d = check_q ^ s_data ^ cnt_inc;
`endif
               end
            end
         end

         ST_SOF: begin
            fifo_wr_en = wr_ok;
            fifo_din   = SOF_BYTE;
            if (wr_ok) begin
               state_d = ST_LEN;
            end
         end

         ST_LEN: begin
            fifo_wr_en = wr_ok;
            fifo_din   = cnt_q;
            if (wr_ok) begin
               state_d  = ST_PAY;
               rd_idx_d = 8'd0;
            end
         end

         ST_PAY: begin
            fifo_wr_en = wr_ok;
            fifo_din   = buf_rd_data;
            if (wr_ok) begin
               rd_idx_d = rd_idx_q + 8'd1;
`ifdef FIFO_FRAME_WRITER_CRC8_EN
               check_d  = crc8_byte(check_q, buf_rd_data);
`endif
               if (rd_idx_q == (cnt_q - 8'd1)) begin
                  state_d = ST_CHK;
               end
            end
         end

         ST_CHK: begin
            fifo_wr_en = wr_ok;
            fifo_din   = check_q;
            if (wr_ok) begin
               state_d  = ST_COLLECT;
               frames_d = frames_q + 16'd1;
               cnt_d    = 8'd0;
               check_d  = 8'd0;
               rd_idx_d = 8'd0;
            end
         end

         default: begin
            state_d = ST_COLLECT;
         end
      endcase
   end

   // State and counter registers; reset drops any frame in progress
   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         state_q  <= ST_COLLECT;
         cnt_q    <= 8'd0;
         rd_idx_q <= 8'd0;
         check_q  <= 8'd0;
         frames_q <= 16'd0;
         split_q  <= 1'b0;
         run_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_idx_q <= rd_idx_d;
         check_q  <= check_d;
         frames_q <= frames_d;
         split_q  <= split_d;
         run_q    <= 1'b1;
      end
   end

   assign frames_sent = frames_q;
   assign split_pulse = split_q;

endmodule
